// File: rtl/w0rm_mem_arbiter.sv
// Two-master (instruction/data) round-robin memory arbiter with per-master
// outstanding-request tracking, tag-based response routing and timeout completions.
module w0rm_mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int USER_WIDTH = 32,
    parameter int MAX_OUTST  = 3,
    parameter int TIMEOUT    = 15
) (
    input  logic                  mem_clk,
    input  logic                  cpu_reset_n,

    input  logic                  i_valid_i,
    input  logic                  i_read_i,
    input  logic                  i_write_i,
    input  logic [ADDR_WIDTH-1:0] i_addr_i,
    input  logic [DATA_WIDTH-1:0] i_data_i,
    input  logic [USER_WIDTH-1:0] i_user_i,
    output logic                  i_ready_o,
    output logic                  i_valid_o,
    output logic [DATA_WIDTH-1:0] i_data_o,
    output logic [USER_WIDTH-1:0] i_user_o,
    output logic                  i_err_o,

    input  logic                  d_valid_i,
    input  logic                  d_read_i,
    input  logic                  d_write_i,
    input  logic [ADDR_WIDTH-1:0] d_addr_i,
    input  logic [DATA_WIDTH-1:0] d_data_i,
    input  logic [USER_WIDTH-1:0] d_user_i,
    output logic                  d_ready_o,
    output logic                  d_valid_o,
    output logic [DATA_WIDTH-1:0] d_data_o,
    output logic [USER_WIDTH-1:0] d_user_o,
    output logic                  d_err_o,

    output logic                  mem_valid_o,
    output logic                  mem_read_o,
    output logic                  mem_write_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_data_o,
    output logic [USER_WIDTH:0]   mem_user_o,

    input  logic                  mem_valid_i,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    input  logic [USER_WIDTH:0]   mem_user_i
);

    localparam logic [2:0] MAX_OUTST_C = 3'(MAX_OUTST);
    localparam logic [7:0] TIMEOUT_C   = 8'(TIMEOUT);

    // Index 0 is the instruction master, index 1 the data master.
    logic [1:0]            req_valid_s;
    logic [1:0]            req_rd_s;
    logic [1:0]            req_wr_s;
    logic [ADDR_WIDTH-1:0] req_addr_s [2];
    logic [DATA_WIDTH-1:0] req_data_s [2];
    logic [USER_WIDTH-1:0] req_user_s [2];

    logic [1:0]            elig_s;
    logic [1:0]            grant_s;
    logic                  gsel_s;
    logic [1:0]            resp_s;
    logic [1:0]            tmo_s;
    logic [1:0]            done_s;

    logic                  last_grant_r;
    logic [2:0]            outst_r [2];
    logic [7:0]            timer_r [2];
    logic [1:0]            rsp_valid_r;
    logic [1:0]            rsp_err_r;
    logic [DATA_WIDTH-1:0] rsp_data_r [2];
    logic [USER_WIDTH-1:0] rsp_user_r [2];

    assign req_valid_s   = {d_valid_i, i_valid_i};
    assign req_rd_s      = {d_read_i, i_read_i};
    assign req_wr_s      = {d_write_i, i_write_i};
    assign req_addr_s[0] = i_addr_i;
    assign req_addr_s[1] = d_addr_i;
    assign req_data_s[0] = i_data_i;
    assign req_data_s[1] = d_data_i;
    assign req_user_s[0] = i_user_i;
    assign req_user_s[1] = d_user_i;

    // Eligibility, response acceptance and timeout detection per master.
    always_comb begin
        elig_s = 2'b00;
        tmo_s  = 2'b00;
        resp_s = 2'b00;
        for (int m = 0; m < 2; m++) begin
            elig_s[m] = cpu_reset_n & req_valid_s[m] & (req_rd_s[m] | req_wr_s[m])
                        & (outst_r[m] < MAX_OUTST_C);
            tmo_s[m]  = (outst_r[m] != 3'd0) & (timer_r[m] == TIMEOUT_C);
        end
        // Responses for a master with nothing outstanding are dropped here.
        resp_s[0] = mem_valid_i & ~mem_user_i[USER_WIDTH] & (outst_r[0] != 3'd0);
        resp_s[1] = mem_valid_i &  mem_user_i[USER_WIDTH] & (outst_r[1] != 3'd0);
        done_s    = resp_s | tmo_s;
    end

    // Round-robin choice: on a tie the master not granted last wins.
    always_comb begin
        grant_s = 2'b00;
        if (elig_s == 2'b11) begin
            if (last_grant_r) begin
                grant_s = 2'b01;
            end else begin
                grant_s = 2'b10;
            end
        end else begin
            grant_s = elig_s;
        end
    end

    assign gsel_s    = grant_s[1];
    assign i_ready_o = grant_s[0];
    assign d_ready_o = grant_s[1];

    // Downstream request register and round-robin history.
    always_ff @(posedge mem_clk or negedge cpu_reset_n) begin
        if (!cpu_reset_n) begin
            last_grant_r <= 1'b0;
            mem_valid_o  <= 1'b0;
            mem_read_o   <= 1'b0;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= '0;
            mem_data_o   <= '0;
            mem_user_o   <= '0;
        end else if (grant_s != 2'b00) begin
            last_grant_r <= gsel_s;
            mem_valid_o  <= 1'b1;
            mem_read_o   <= req_rd_s[gsel_s];
            mem_write_o  <= req_wr_s[gsel_s];
            mem_addr_o   <= req_addr_s[gsel_s];
            mem_data_o   <= req_data_s[gsel_s];
            mem_user_o   <= {gsel_s, req_user_s[gsel_s]};
        end else begin
            last_grant_r <= last_grant_r;
            mem_valid_o  <= 1'b0;
            mem_read_o   <= 1'b0;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= '0;
            mem_data_o   <= '0;
            mem_user_o   <= '0;
        end
    end

    // Outstanding counters, inactivity timers and registered completions.
    always_ff @(posedge mem_clk or negedge cpu_reset_n) begin
        if (!cpu_reset_n) begin
            for (int m = 0; m < 2; m++) begin
                outst_r[m]     <= 3'd0;
                timer_r[m]     <= 8'd0;
                rsp_valid_r[m] <= 1'b0;
                rsp_err_r[m]   <= 1'b0;
                rsp_data_r[m]  <= '0;
                rsp_user_r[m]  <= '0;
            end
        end else begin
            for (int m = 0; m < 2; m++) begin
                if (done_s[m] && !grant_s[m]) begin
                    outst_r[m] <= outst_r[m] - 3'd1;
                end else if (grant_s[m] && !done_s[m]) begin
                    outst_r[m] <= outst_r[m] + 3'd1;
                end else begin
                    outst_r[m] <= outst_r[m];
                end

                if (done_s[m] || (outst_r[m] == 3'd0)) begin
                    timer_r[m] <= 8'd0;
                end else begin
                    timer_r[m] <= timer_r[m] + 8'd1;
                end

                // A real response beats a timeout landing in the same cycle.
                if (resp_s[m]) begin
                    rsp_valid_r[m] <= 1'b1;
                    rsp_err_r[m]   <= 1'b0;
                    rsp_data_r[m]  <= mem_data_i;
                    rsp_user_r[m]  <= mem_user_i[USER_WIDTH-1:0];
                end else if (tmo_s[m]) begin
                    rsp_valid_r[m] <= 1'b1;
                    rsp_err_r[m]   <= 1'b1;
                    rsp_data_r[m]  <= '0;
                    rsp_user_r[m]  <= '0;
                end else begin
                    rsp_valid_r[m] <= 1'b0;
                    rsp_err_r[m]   <= 1'b0;
                    rsp_data_r[m]  <= '0;
                    rsp_user_r[m]  <= '0;
                end
            end
        end
    end

    assign i_valid_o = rsp_valid_r[0];
    assign i_err_o   = rsp_err_r[0];
    assign i_data_o  = rsp_data_r[0];
    assign i_user_o  = rsp_user_r[0];
    assign d_valid_o = rsp_valid_r[1];
    assign d_err_o   = rsp_err_r[1];
    assign d_data_o  = rsp_data_r[1];
    assign d_user_o  = rsp_user_r[1];

endmodule

// File: tb/tb_w0rm_mem_arbiter.sv
// Self-checking bench for w0rm_mem_arbiter: directed vector table, corner-case
// sequences and randomized traffic against a deadline-based reference model.
module tb_w0rm_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int UW = 32;
    localparam int MO = 3;
    localparam int TO = 15;

    logic          mem_clk = 1'b0;
    logic          cpu_reset_n = 1'b0;
    logic          i_valid_i, i_read_i, i_write_i;
    logic [AW-1:0] i_addr_i;
    logic [DW-1:0] i_data_i;
    logic [UW-1:0] i_user_i;
    logic          i_ready_o, i_valid_o, i_err_o;
    logic [DW-1:0] i_data_o;
    logic [UW-1:0] i_user_o;
    logic          d_valid_i, d_read_i, d_write_i;
    logic [AW-1:0] d_addr_i;
    logic [DW-1:0] d_data_i;
    logic [UW-1:0] d_user_i;
    logic          d_ready_o, d_valid_o, d_err_o;
    logic [DW-1:0] d_data_o;
    logic [UW-1:0] d_user_o;
    logic          mem_valid_o, mem_read_o, mem_write_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_data_o;
    logic [UW:0]   mem_user_o;
    logic          mem_valid_i;
    logic [DW-1:0] mem_data_i;
    logic [UW:0]   mem_user_i;

    w0rm_mem_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .USER_WIDTH(UW), .MAX_OUTST(MO), .TIMEOUT(TO)
    ) dut (
        .mem_clk(mem_clk), .cpu_reset_n(cpu_reset_n),
        .i_valid_i(i_valid_i), .i_read_i(i_read_i), .i_write_i(i_write_i),
        .i_addr_i(i_addr_i), .i_data_i(i_data_i), .i_user_i(i_user_i), .i_ready_o(i_ready_o),
        .i_valid_o(i_valid_o), .i_data_o(i_data_o), .i_user_o(i_user_o), .i_err_o(i_err_o),
        .d_valid_i(d_valid_i), .d_read_i(d_read_i), .d_write_i(d_write_i),
        .d_addr_i(d_addr_i), .d_data_i(d_data_i), .d_user_i(d_user_i), .d_ready_o(d_ready_o),
        .d_valid_o(d_valid_o), .d_data_o(d_data_o), .d_user_o(d_user_o), .d_err_o(d_err_o),
        .mem_valid_o(mem_valid_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_user_o(mem_user_o),
        .mem_valid_i(mem_valid_i), .mem_data_i(mem_data_i), .mem_user_i(mem_user_i)
    );

    always #5 mem_clk = ~mem_clk;

    int n_pass  = 0;
    int n_total = 0;
    logic [1:0] smp_rdy;

    // Reference model: outstanding count per master and the absolute edge
    // number at which that master's timeout error completion is due.
    int     mdl_outst    [2];
    longint mdl_deadline [2];
    bit     mdl_last_d;
    longint mdl_edge;

    typedef struct {
        logic iv, irw, dv;
        logic exp_ir, exp_dr, exp_mv, exp_tag;
    } vec_t;
    vec_t tbl [9];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic idle();
        i_valid_i = 1'b0; i_read_i = 1'b0; i_write_i = 1'b0;
        i_addr_i = '0; i_data_i = '0; i_user_i = '0;
        d_valid_i = 1'b0; d_read_i = 1'b0; d_write_i = 1'b0;
        d_addr_i = '0; d_data_i = '0; d_user_i = '0;
        mem_valid_i = 1'b0; mem_data_i = '0; mem_user_i = '0;
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            mdl_outst[m]    = 0;
            mdl_deadline[m] = -1;
        end
        mdl_last_d = 1'b0;
        mdl_edge   = 0;
    endtask

    // One clock: predict from current inputs, check ready mid-cycle and the
    // registered outputs just after the edge, then advance the model.
    task automatic step();
        logic [1:0]   elig, grant, done, rsp_ok, tmo, v, rw;
        logic [255:0] exp_mem, exp_rsp [2];
        longint e;
        int tgt, nw;
        @(negedge mem_clk);
        e  = mdl_edge + 1;
        v  = {d_valid_i, i_valid_i};
        rw = {d_read_i | d_write_i, i_read_i | i_write_i};
        for (int m = 0; m < 2; m++) elig[m] = v[m] && rw[m] && (mdl_outst[m] < MO);
        if (elig == 2'b11) grant = mdl_last_d ? 2'b01 : 2'b10;
        else grant = elig;
        exp_mem = '0;
        if (grant[0]) exp_mem = {1'b1, i_read_i, i_write_i, i_addr_i, i_data_i, 1'b0, i_user_i};
        else if (grant[1]) exp_mem = {1'b1, d_read_i, d_write_i, d_addr_i, d_data_i, 1'b1, d_user_i};
        tgt    = int'(mem_user_i[UW]);
        rsp_ok = 2'b00;
        if (mem_valid_i && mdl_outst[tgt] > 0) rsp_ok[tgt] = 1'b1;
        for (int m = 0; m < 2; m++) begin
            tmo[m] = (mdl_outst[m] > 0) && (mdl_deadline[m] == e);
            if (rsp_ok[m]) exp_rsp[m] = {1'b1, 1'b0, mem_data_i, mem_user_i[UW-1:0]};
            else if (tmo[m]) exp_rsp[m] = {1'b1, 1'b1, {DW{1'b0}}, {UW{1'b0}}};
            else exp_rsp[m] = '0;
            done[m] = rsp_ok[m] | tmo[m];
        end
        smp_rdy = {d_ready_o, i_ready_o};
        chk("ready", smp_rdy, grant);
        @(posedge mem_clk);
        #1;
        chk("mem_req", {mem_valid_o, mem_read_o, mem_write_o, mem_addr_o, mem_data_o, mem_user_o}, exp_mem);
        chk("i_rsp", {i_valid_o, i_err_o, i_data_o, i_user_o}, exp_rsp[0]);
        chk("d_rsp", {d_valid_o, d_err_o, d_data_o, d_user_o}, exp_rsp[1]);
        for (int m = 0; m < 2; m++) begin
            nw = mdl_outst[m] + int'(grant[m]) - int'(done[m]);
            if (done[m] && nw > 0) mdl_deadline[m] = e + TO + 1;
            else if (mdl_outst[m] == 0 && grant[m]) mdl_deadline[m] = e + TO + 1;
            mdl_outst[m] = nw;
        end
        if (grant != 2'b00) mdl_last_d = grant[1];
        mdl_edge = e;
    endtask

    task automatic do_reset();
        idle();
        @(posedge mem_clk);
        #2;
        cpu_reset_n = 1'b0;
        #1;
        chk("reset_outputs", {i_ready_o, d_ready_o, mem_valid_o, mem_read_o, mem_write_o,
            mem_addr_o, mem_data_o, mem_user_o, i_valid_o, i_err_o, i_data_o, i_user_o,
            d_valid_o, d_err_o, d_data_o, d_user_o}, '0);
        model_reset();
        @(posedge mem_clk);
        #1;
        cpu_reset_n = 1'b1;
    endtask

    task automatic rand_inputs();
        i_valid_i = 1'($urandom_range(0, 1));
        i_read_i  = 1'($urandom_range(0, 1));
        i_write_i = ($urandom_range(0, 3) == 0);
        i_addr_i  = AW'($urandom);
        i_data_i  = DW'($urandom);
        i_user_i  = UW'($urandom);
        d_valid_i = 1'($urandom_range(0, 1));
        d_read_i  = 1'($urandom_range(0, 1));
        d_write_i = ($urandom_range(0, 3) == 0);
        d_addr_i  = AW'($urandom);
        d_data_i  = DW'($urandom);
        d_user_i  = UW'($urandom);
        mem_valid_i = ($urandom_range(0, 3) == 0);
        mem_data_i  = DW'($urandom);
        mem_user_i  = {1'($urandom_range(0, 1)), UW'($urandom)};
    endtask

    initial begin
        int found;
        int strobes;
        // iv irw dv | exp i_ready d_ready mem_valid tag
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        idle();
        model_reset();
        do_reset();

        // Tie after reset, alternation, then both masters saturated.
        for (int k = 0; k < 9; k++) begin
            i_valid_i = tbl[k].iv; i_read_i = tbl[k].irw; i_write_i = 1'b0;
            i_addr_i = 32'h0000_1000 + AW'(k); i_user_i = UW'(k);
            d_valid_i = tbl[k].dv; d_read_i = 1'b1; d_write_i = 1'b0;
            d_addr_i = 32'h8000_2000 + AW'(k); d_user_i = UW'(k + 16);
            step();
            chk($sformatf("tbl%0d_ready", k), smp_rdy, {tbl[k].exp_dr, tbl[k].exp_ir});
            chk($sformatf("tbl%0d_mv_tag", k), {mem_valid_o, mem_user_o[UW]},
                {tbl[k].exp_mv, tbl[k].exp_tag});
        end

        // Outstanding limit: fourth i attempt refused while d is granted.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            idle();
            i_valid_i = 1'b1; i_read_i = 1'b1; i_addr_i = AW'(k * 4);
            step();
            chk($sformatf("limit_acc%0d", k), smp_rdy, 2'b01);
        end
        i_valid_i = 1'b1; i_read_i = 1'b1;
        d_valid_i = 1'b1; d_write_i = 1'b1; d_data_i = 32'h0BAD_F00D;
        step();
        chk("limit_4th", smp_rdy, 2'b10);

        // Response routing to d.
        do_reset();
        idle();
        d_valid_i = 1'b1; d_read_i = 1'b1; d_addr_i = 32'h4000_0004; d_user_i = 32'h55;
        step();
        chk("route_req", {mem_valid_o, mem_read_o, mem_addr_o, mem_user_o},
            {1'b1, 1'b1, 32'h4000_0004, 33'h1_0000_0055});
        idle();
        mem_valid_i = 1'b1; mem_data_i = 32'hDEAD_BEEF; mem_user_i = 33'h1_0000_0055;
        step();
        chk("route_d", {d_valid_o, d_data_o, d_user_o, d_err_o}, {1'b1, 32'hDEAD_BEEF, 32'h55, 1'b0});
        chk("route_i_quiet", {i_valid_o, i_data_o, i_user_o, i_err_o}, '0);

        // Timeout: unanswered i request completes with error TO+1 edges later.
        do_reset();
        idle();
        i_valid_i = 1'b1; i_read_i = 1'b1; i_addr_i = 32'hF000_0000; i_user_i = 32'h1;
        step();
        idle();
        found = -1;
        for (int k = 1; k <= 40 && found < 0; k++) begin
            step();
            if (i_valid_o) found = k;
        end
        chk("tmo_latency", found, TO + 1);
        chk("tmo_err", {i_valid_o, i_err_o, i_data_o, i_user_o}, {1'b1, 1'b1, 64'h0});
        for (int k = 0; k < 3; k++) begin
            i_valid_i = 1'b1; i_read_i = 1'b1;
            step();
            chk($sformatf("tmo_refill%0d", k), smp_rdy[0], 1'b1);
        end

        // Response on the very cycle the timer expires: one non-error completion.
        do_reset();
        idle();
        i_valid_i = 1'b1; i_read_i = 1'b1; i_user_i = 32'hA5;
        step();
        idle();
        for (int k = 1; k <= TO; k++) step();
        mem_valid_i = 1'b1; mem_data_i = 32'h1234_5678; mem_user_i = 33'h0_0000_00A5;
        step();
        chk("collide", {i_valid_o, i_err_o, i_data_o, i_user_o}, {1'b1, 1'b0, 32'h1234_5678, 32'hA5});
        idle();
        step();
        chk("collide_once", {i_valid_o, i_err_o}, 2'b00);

        // Reset with two outstanding per master: nothing completes afterwards.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            i_valid_i = 1'b1; i_read_i = 1'b1; d_valid_i = 1'b1; d_read_i = 1'b1;
            step();
        end
        do_reset();
        strobes = 0;
        for (int k = 0; k < 40; k++) begin
            idle();
            if (k < 2) begin
                mem_valid_i = 1'b1;
                mem_user_i  = {1'(k), 32'h77};
            end
            step();
            if (i_valid_o || d_valid_o) strobes++;
        end
        chk("post_reset_quiet", strobes, 0);

        // Randomized traffic against the model.
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            rand_inputs();
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
